soundbar_level_ctrl: RTL

//  Drives the 16-level OLED sound bar. Takes raw 12-bit mic samples and tracks the peak

---
 rtl/soundbar_level_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/soundbar_level_ctrl.sv
// rtl/soundbar_level_ctrl.sv - mic peak window to frame-synchronous sound-bar level and peak marker
// Levels only change on an unfrozen frame_begin so the bar never tears mid-frame.
module soundbar_level_ctrl #(
   parameter int WINDOW       = 4000,
   parameter int MIC_FLOOR    = 2048,
   parameter int HOLD_FRAMES  = 30,
   parameter int DECAY_FRAMES = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        sample_valid,
   input  logic [11:0] mic_in,
   input  logic        frame_begin,
   input  logic        freeze,
   output logic [15:0] level_therm,
   output logic [4:0]  level_idx,
   output logic [4:0]  peak_idx,
   output logic        level_valid
);

   localparam int CW = (WINDOW > 1)       ? $clog2(WINDOW)       : 1;
   localparam int HW = (HOLD_FRAMES > 1)  ? $clog2(HOLD_FRAMES)  : 1;
   localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

   typedef enum logic {PK_HOLD, PK_DECAY} pk_state_t;

   pk_state_t       pk_state;
   logic [CW-1:0]   cnt;
   logic [11:0]     cur_max;
   logic [4:0]      win_lvl;
   logic            pending;
   logic [HW-1:0]   hold_cnt;
   logic [DW-1:0]   decay_cnt;

   logic [11:0]     amp;
   logic [11:0]     win_max;
   logic [4:0]      win_next;
   logic [4:0]      new_lvl;
   logic            frame_go;
   logic            commit;

   function automatic logic [15:0] therm(input logic [4:0] n);
      logic [16:0] t;
      t = (17'd1 << n) - 17'd1;
      return t[15:0];
   endfunction

   always_comb begin
      amp = '0;
      if (mic_in >= 12'(MIC_FLOOR))
         amp = mic_in - 12'(MIC_FLOOR);
      else
         amp = 12'(MIC_FLOOR) - mic_in;
      win_max  = (amp > cur_max) ? amp : cur_max;
      win_next = (win_max[11:7] > 5'd16) ? 5'd16 : win_max[11:7];
      frame_go = frame_begin & ~freeze;
      commit   = frame_go & pending;
      // The peak FSM sees the level as it will be after this frame's commit.
      new_lvl  = commit ? win_lvl : level_idx;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         level_therm <= '0;
         level_idx   <= '0;
         peak_idx    <= '0;
         level_valid <= 1'b0;
         pk_state    <= PK_HOLD;
         cnt         <= '0;
         cur_max     <= '0;
         win_lvl     <= '0;
         pending     <= 1'b0;
         hold_cnt    <= '0;
         decay_cnt   <= '0;
      end else begin
         level_valid <= commit;
         if (commit) begin
            level_idx   <= win_lvl;
            level_therm <= therm(win_lvl);
            pending     <= 1'b0;
         end

         if (frame_go) begin
            if (new_lvl >= peak_idx) begin
               peak_idx <= new_lvl;
               hold_cnt <= HW'(HOLD_FRAMES - 1);
               pk_state <= PK_HOLD;
            end else begin
               case (pk_state)
                  PK_HOLD: begin
                     if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                     end else begin
                        pk_state  <= PK_DECAY;
                        decay_cnt <= DW'(DECAY_FRAMES - 1);
                     end
                  end
                  PK_DECAY: begin
                     if (decay_cnt != '0) begin
                        decay_cnt <= decay_cnt - 1'b1;
                     end else begin
                        decay_cnt <= DW'(DECAY_FRAMES - 1);
                        if ((peak_idx - 5'd1) <= new_lvl) begin
                           peak_idx <= new_lvl;
                           pk_state <= PK_HOLD;
                           hold_cnt <= '0;
                        end else begin
                           peak_idx <= peak_idx - 5'd1;
                        end
                     end
                  end
                  default: pk_state <= PK_HOLD;
               endcase
            end
         end

         // Placed after the commit so a window closing on a frame edge stays pending.
         if (sample_valid) begin
            if (cnt == CW'(WINDOW - 1)) begin
               win_lvl <= win_next;
               pending <= 1'b1;
               cur_max <= '0;
               cnt     <= '0;
            end else begin
               cur_max <= win_max;
               cnt     <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
